// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared state codes, field widths and score helper for the
//               game sequencer.
// Revision    : 1.0
// ============================================================================
package game_pkg;

    localparam int STEP_W   = 4;
    localparam int SCORE_W  = 8;
    localparam int PLAYER_W = 3;
    localparam int ROUND_W  = 4;

    typedef enum logic [STEP_W-1:0] {
        S_IDLE     = 4'd0,
        S_GEN      = 4'd1,
        S_SHOW     = 4'd2,
        S_WAIT_SEL = 4'd3,
        S_CHECK    = 4'd4,
        S_NEXT     = 4'd5,
        S_DONE     = 4'd6
    } state_t;

    // Scores stick at full scale instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_if
// Description : Control inputs and status outputs of the game sequencer.
// Revision    : 1.0
// ============================================================================
interface game_sequencer_if #(
    parameter int PLAYERS = 2
) ();

    logic                                     start;
    logic                                     rand_ready;
    logic                                     show_done;
    logic                                     select;
    logic                                     result_valid;
    logic                                     win;
    logic                                     finish;
    logic [game_pkg::STEP_W-1:0]              step;
    logic [game_pkg::PLAYER_W-1:0]            player;
    logic [game_pkg::ROUND_W-1:0]             round;
    logic                                     timeout;
    logic                                     game_over;
    logic [game_pkg::PLAYER_W-1:0]            winner;
    logic [game_pkg::SCORE_W*PLAYERS-1:0]     score;

    modport master (
        output start, rand_ready, show_done, select, result_valid, win, finish,
        input  step, player, round, timeout, game_over, winner, score
    );

    modport slave (
        input  start, rand_ready, show_done, select, result_valid, win, finish,
        output step, player, round, timeout, game_over, winner, score
    );

endinterface
`default_nettype wire

// File: rtl/game_sequencer_turn_timer.sv
`default_nettype none
// ============================================================================
// Module      : turn_timer
// Description : Per-turn cycle counter; expired flags the last allowed cycle.
// Revision    : 1.0
// ============================================================================
module turn_timer #(
    parameter int TIMEOUT = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int               CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Turn/round sequencer for a multi-player pattern game.
// Revision    : 1.0
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int PLAYERS = 2,
    parameter int ROUNDS  = 4,
    parameter int TIMEOUT = 1000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    game_sequencer_if.slave bus
);

    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(PLAYERS - 1);
    localparam logic [ROUND_W-1:0]  LAST_ROUND  = ROUND_W'(ROUNDS - 1);

    state_t                            state;
    logic [PLAYER_W-1:0]               player;
    logic [ROUND_W-1:0]                round;
    logic                              timeout;
    logic                              game_over;
    logic [PLAYER_W-1:0]               winner;
    logic [PLAYERS-1:0][SCORE_W-1:0]   scores;
    logic [PLAYER_W-1:0]               leader;
    logic [SCORE_W-1:0]                best;
    logic                              expired;

    turn_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != S_WAIT_SEL),
        .enable  (state == S_WAIT_SEL),
        .expired (expired)
    );

    // Strict greater-than keeps ties on the lowest index.
    always_comb begin
        leader = '0;
        best   = scores[0];
        for (int i = 1; i < PLAYERS; i++) begin
            if (scores[i] > best) begin
                best   = scores[i];
                leader = PLAYER_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            player    <= '0;
            round     <= '0;
            timeout   <= 1'b0;
            game_over <= 1'b0;
            winner    <= '0;
            scores    <= '0;
        end else begin
            timeout <= 1'b0;
            if (bus.finish && (state != S_IDLE)) begin
                state     <= S_IDLE;
                game_over <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state  <= S_GEN;
                            player <= '0;
                            round  <= '0;
                            scores <= '0;
                        end
                    end
                    S_GEN: begin
                        if (bus.rand_ready) state <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (bus.show_done) state <= S_WAIT_SEL;
                    end
                    S_WAIT_SEL: begin
                        if (bus.select) begin
                            state <= S_CHECK;
                        end else if (expired) begin
                            timeout <= 1'b1;
                            state   <= S_NEXT;
                        end
                    end
                    S_CHECK: begin
                        if (bus.result_valid) begin
                            if (bus.win) begin
                                for (int i = 0; i < PLAYERS; i++) begin
                                    if (player == PLAYER_W'(i)) scores[i] <= sat_inc(scores[i]);
                                end
                            end
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (player == LAST_PLAYER) begin
                            if (round == LAST_ROUND) begin
                                state     <= S_DONE;
                                game_over <= 1'b1;
                                winner    <= leader;
                            end else begin
                                player <= '0;
                                round  <= round + 1'b1;
                                state  <= S_GEN;
                            end
                        end else begin
                            player <= player + 1'b1;
                            state  <= S_GEN;
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.step      = state;
    assign bus.player    = player;
    assign bus.round     = round;
    assign bus.timeout   = timeout;
    assign bus.game_over = game_over;
    assign bus.winner    = winner;
    assign bus.score     = scores;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed scoreboard bench; every change of the output tuple
//               is matched against the next queued expectation.
// Revision    : 1.0
// ============================================================================
module tb_game_sequencer;
    import game_pkg::*;

    localparam int PLAYERS = 2;
    localparam int ROUNDS  = 2;
    localparam int TIMEOUT = 8;

    typedef struct {
        string       tag;
        logic [31:0] val;
        int          gap;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int         p;
    int         r;
    logic [7:0] s[2];
    logic [2:0] w;
    logic       go;

    game_sequencer_if #(.PLAYERS(PLAYERS)) bus ();

    game_sequencer #(
        .PLAYERS (PLAYERS),
        .ROUNDS  (ROUNDS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [3:0] st, input logic to);
        return {st, 3'(p), 4'(r), to, go, w, s[1], s[0]};
    endfunction

    task automatic push(input string tag, input logic [3:0] st, input logic to, input int gap);
        exp_t e;
        e.tag = tag;
        e.val = pack(st, to);
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input int which);
        case (which)
            0: bus.start      = 1'b1;
            1: bus.rand_ready = 1'b1;
            2: bus.show_done  = 1'b1;
            3: bus.select     = 1'b1;
            default: bus.finish = 1'b1;
        endcase
        tick();
        bus.start = 1'b0; bus.rand_ready = 1'b0; bus.show_done = 1'b0;
        bus.select = 1'b0; bus.finish = 1'b0;
    endtask

    task automatic result(input logic won);
        bus.result_valid = 1'b1;
        bus.win          = won;
        tick();
        bus.result_valid = 1'b0;
        bus.win          = 1'b0;
    endtask

    // Expected effect of the one-cycle NEXT state on the model.
    task automatic advance(input string tag);
        if (r == ROUNDS - 1 && p == PLAYERS - 1) begin
            go = 1'b1;
            w  = (s[1] > s[0]) ? 3'd1 : 3'd0;
            push({tag, " done"}, S_DONE, 1'b0, 1);
        end else begin
            if (p < PLAYERS - 1) p++;
            else begin p = 0; r++; end
            push({tag, " gen"}, S_GEN, 1'b0, 1);
        end
    endtask

    task automatic turn(input logic won, input string tag);
        push({tag, " show"}, S_SHOW, 1'b0, -1);     strobe(1);
        push({tag, " wait"}, S_WAIT_SEL, 1'b0, -1); strobe(2);
        push({tag, " check"}, S_CHECK, 1'b0, -1);   strobe(3);
        if (won) s[p] = (s[p] == 8'hFF) ? 8'hFF : s[p] + 8'd1;
        push({tag, " next"}, S_NEXT, 1'b0, 1);
        advance(tag);
        result(won);
        tick();
    endtask

    // Monitor: any change of the observable outputs is one DUT event.
    initial begin
        logic [31:0] cur;
        logic [31:0] prev;
        logic        have;
        int          since;
        exp_t        e;
        have  = 1'b0;
        since = 0;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = {bus.step, bus.player, bus.round, bus.timeout, bus.game_over,
                   bus.winner, bus.score};
            since++;
            if (!have || cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected event: got %h, wanted no change", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.val || (e.gap >= 0 && since != e.gap)) begin
                        errors++;
                        $display("FAIL %s: got %h after %0d cycles, wanted %h after %0d",
                                 e.tag, cur, since, e.val, e.gap);
                    end
                end
                have  = 1'b1;
                prev  = cur;
                since = 0;
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.rand_ready = 1'b0; bus.show_done = 1'b0;
        bus.select = 1'b0; bus.result_valid = 1'b0; bus.win = 1'b0; bus.finish = 1'b0;
        p = 0; r = 0; s[0] = 8'd0; s[1] = 8'd0; w = 3'd0; go = 1'b0;
        push("reset", S_IDLE, 1'b0, -1);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Game A: every turn won, tie goes to player 0
        push("A start", S_GEN, 1'b0, -1); strobe(0);
        turn(1'b1, "A t0");
        turn(1'b1, "A t1");
        turn(1'b1, "A t2");
        turn(1'b1, "A t3");
        strobe(0);
        tick();
        go = 1'b0;
        push("A finish", S_IDLE, 1'b0, -1); strobe(4);
        tick();

        // Game B: timeout, select on expiry, finish in SHOW
        p = 0; r = 0; s[0] = 8'd0; s[1] = 8'd0;
        push("B start", S_GEN, 1'b0, -1); strobe(0);
        push("B to show", S_SHOW, 1'b0, -1);     strobe(1);
        push("B to wait", S_WAIT_SEL, 1'b0, -1); strobe(2);
        push("B timeout", S_NEXT, 1'b1, TIMEOUT);
        advance("B timeout");
        repeat (10) tick();
        push("B exp show", S_SHOW, 1'b0, -1);     strobe(1);
        push("B exp wait", S_WAIT_SEL, 1'b0, -1); strobe(2);
        repeat (TIMEOUT - 1) tick();
        push("B exp check", S_CHECK, 1'b0, TIMEOUT); strobe(3);
        s[1] = 8'd1;
        push("B exp next", S_NEXT, 1'b0, 1);
        advance("B exp");
        result(1'b1);
        tick();
        push("B r1 show", S_SHOW, 1'b0, -1); strobe(1);
        push("B abort", S_IDLE, 1'b0, -1);   strobe(4);
        tick();
        p = 0; r = 0; s[0] = 8'd0; s[1] = 8'd0;
        push("B restart", S_GEN, 1'b0, -1); strobe(0);

        // Reset taken from CHECK, start held under reset
        push("R show", S_SHOW, 1'b0, -1);     strobe(1);
        push("R wait", S_WAIT_SEL, 1'b0, -1); strobe(2);
        push("R check", S_CHECK, 1'b0, -1);   strobe(3);
        push("R reset", S_IDLE, 1'b0, -1);
        rst = 1'b0; bus.result_valid = 1'b1; bus.win = 1'b1;
        tick();
        bus.result_valid = 1'b0; bus.win = 1'b0; bus.start = 1'b1;
        repeat (3) tick();
        bus.start = 1'b0; rst = 1'b1;
        tick();

        // Game C: player 1 sits at full scale and keeps winning
        push("C start", S_GEN, 1'b0, -1); strobe(0);
        s[1] = 8'hFF;
        push("C forced", S_GEN, 1'b0, -1);
        force dut.scores = 16'hFF00;
        tick();
        release dut.scores;
        tick();
        turn(1'b0, "C t0");
        turn(1'b1, "C t1");
        turn(1'b0, "C t2");
        turn(1'b1, "C t3");
        go = 1'b0;
        push("C finish", S_IDLE, 1'b0, -1); strobe(4);

        repeat (5) tick();
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no event, wanted %h", e.tag, e.val);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
